fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset, word-aligned.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): ifInstr value when no valid instruction is held.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port redirect, input, 1 bit: taken branch or jump from execute.
REQ-006 SHALL have port redirectPC, input, 32 bits: redirect target.
REQ-007 SHALL have port imemReq, output, 1 bit: fetch request to instruction memory.
REQ-008 SHALL have port imemAddr, output, 32 bits: fetch address, always equal to the PC register.
REQ-009 SHALL have port imemGnt, input, 1 bit: memory accepted the request this cycle.
REQ-010 SHALL have port imemValid, input, 1 bit: response data valid.
REQ-011 SHALL have port imemData, input, 32 bits: fetched instruction.
REQ-012 SHALL have port ifValid, output, 1 bit: instruction presented to decode (controller opcode/f3/f7 source).
REQ-013 SHALL have port ifInstr, output, 32 bits: presented instruction.
REQ-014 SHALL have port ifPC, output, 32 bits: address of ifInstr.
REQ-015 SHALL have port ifReady, input, 1 bit: decode accepts the presented instruction.

Function
REQ-016 SHALL implement states FETCH, WAIT and FLUSH, with at most one memory request outstanding.
REQ-017 SHALL drive imemReq = (state==FETCH) && (!ifValid || ifReady) && !redirect.
REQ-018 SHALL, in FETCH with imemReq && imemGnt, go to WAIT.
REQ-019 SHALL, in WAIT on imemValid without redirect, capture ifInstr<=imemData, ifPC<=pc, ifValid<=1, pc<=pc+4, then go to FETCH.
REQ-020 SHALL keep PC arithmetic mod 2^32: pc 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-021 SHALL clear ifValid when ifValid && ifReady at an edge where no new capture occurs; capture takes precedence on the same edge.
REQ-022 SHALL hold ifInstr and ifPC stable while ifValid && !ifReady.
REQ-023 SHALL drive ifInstr=NOP_INSTR whenever ifValid=0.
REQ-024 SHALL treat redirect as highest priority: pc<={redirectPC[31:2],2'b00} (misaligned low bits dropped), ifValid<=0, and any captured response discarded.
REQ-025 SHALL make the redirect next-state FLUSH if a request is outstanding after the edge (WAIT without imemValid, or FLUSH without imemValid); otherwise FETCH.
REQ-026 SHALL, in FLUSH, discard the response on imemValid and go to FETCH; a redirect in FLUSH updates pc only.
REQ-027 SHALL ignore imemValid in FETCH and imemGnt outside FETCH.
REQ-028 SHALL give latency: redirect sampled at edge N -> imemReq with imemAddr=target in cycle N+1 if not FLUSH.
REQ-029 SHALL give latency: imemValid at edge N -> ifValid in cycle N+1.
REQ-030 SHALL, with zero-wait memory (gnt with req, valid next cycle), sustain one instruction per 2 cycles.

Reset
REQ-031 SHALL, on rst_n low asynchronously, set: state FETCH, pc=RESET_PC, ifValid=0, ifInstr=NOP_INSTR, ifPC=0, imemReq=0.
REQ-032 SHALL drop any response outstanding at reset via REQ-027.
REQ-033 SHALL raise imemReq with imemAddr=RESET_PC in the first cycle after rst_n deasserts.

Verification
REQ-034 SHALL cover: reset release, zero-wait memory, ifReady=1 -> imemAddr 0x0, 0x4, 0x8; ifPC 0x0, 0x4, 0x8 with ifValid every 2nd cycle.
REQ-035 SHALL cover: ifReady=0 for 5 cycles with ifValid=1, ifPC=0x4 -> ifInstr and ifPC stable, imemReq=0; ifReady=1 -> next request to 0x8.
REQ-036 SHALL cover: redirect to 0x100 while in WAIT, memory returns 2 cycles later -> response dropped, ifValid=0, next imemAddr=0x100, first ifPC=0x100.
REQ-037 SHALL cover: redirect to 0x203 on the same edge as imemValid -> data dropped, imemAddr=0x200 the next cycle.
REQ-038 SHALL cover: RESET_PC=32'hFFFF_FFFC -> second imemAddr=0x0, ifPC sequence 0xFFFF_FFFC then 0x0.
REQ-039 SHALL cover: rst_n pulsed low in WAIT, late imemValid after release -> outputs at reset values immediately, late data ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus bundle: redirect, imem request/response and decode handoff
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemValid;
  logic [31:0] imemData;
  logic        ifValid;
  logic [31:0] ifInstr;
  logic [31:0] ifPC;
  logic        ifReady;

  modport master (
    input  redirect, redirectPC,
    output imemReq, imemAddr,
    input  imemGnt, imemValid, imemData,
    output ifValid, ifInstr, ifPC,
    input  ifReady
  );

  modport slave (
    output redirect, redirectPC,
    input  imemReq, imemAddr,
    output imemGnt, imemValid, imemData,
    input  ifValid, ifInstr, ifPC,
    output ifReady
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit with redirect/flush handling
// Holds one fetched instruction for decode; a redirect drops anything in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        req;

  // Request is masked while reset is held so the bus is quiet during reset.
  assign req = rst_n && (state_q == FETCH) && (!if_valid_q || bus.ifReady) && !bus.redirect;

  assign bus.imemReq  = req;
  assign bus.imemAddr = pc_q;
  assign bus.ifValid  = if_valid_q;
  assign bus.ifInstr  = if_valid_q ? if_instr_q : NOP_INSTR;
  assign bus.ifPC     = if_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (bus.redirect) begin
      pc_d       = bus.redirectPC & 32'hFFFF_FFFC;
      if_valid_d = 1'b0;
      // A response still owed by memory must be swallowed before fetching again.
      if ((state_q == WAIT || state_q == FLUSH) && !bus.imemValid) begin
        state_d = FLUSH;
      end else begin
        state_d = FETCH;
      end
    end else begin
      if (if_valid_q && bus.ifReady) begin
        if_valid_d = 1'b0;
      end
      case (state_q)
        FETCH: begin
          if (req && bus.imemGnt) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (bus.imemValid) begin
            if_instr_d = bus.imemData;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH;
          end
        end
        FLUSH: begin
          if (bus.imemValid) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, corner sequences, random run
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  fetch_unit_if ifa();
  fetch_unit_if ifb();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ifa));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ifb));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        valid;
    logic [31:0] daddr;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        eifv;
    logic [31:0] eifpc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F00;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr, input logic v,
                         input logic [31:0] instr, input logic [31:0] pc, input logic ereq,
                         input logic [31:0] eaddr, input logic eifv, input logic [31:0] epc);
    check({tag, ".imemReq"}, 32'(req), 32'(ereq));
    check({tag, ".imemAddr"}, addr, eaddr);
    check({tag, ".ifValid"}, 32'(v), 32'(eifv));
    check({tag, ".ifPC"}, pc, epc);
    check({tag, ".ifInstr"}, instr, eifv ? mem_of(epc) : NOP);
  endtask

  task automatic chk_a(input string tag, input logic ereq, input logic [31:0] eaddr,
                       input logic eifv, input logic [31:0] epc);
    chk_out(tag, ifa.imemReq, ifa.imemAddr, ifa.ifValid, ifa.ifInstr, ifa.ifPC, ereq, eaddr, eifv, epc);
  endtask

  task automatic chk_b(input string tag, input logic ereq, input logic [31:0] eaddr,
                       input logic eifv, input logic [31:0] epc);
    chk_out(tag, ifb.imemReq, ifb.imemAddr, ifb.ifValid, ifb.ifInstr, ifb.ifPC, ereq, eaddr, eifv, epc);
  endtask

  task automatic drive_a(input logic redir, input logic [31:0] rpc, input logic gnt, input logic valid,
                         input logic [31:0] data, input logic rdy);
    ifa.redirect   = redir;
    ifa.redirectPC = rpc;
    ifa.imemGnt    = gnt;
    ifa.imemValid  = valid;
    ifa.imemData   = data;
    ifa.ifReady    = rdy;
  endtask

  task automatic row(input logic r, input logic rd, input logic [31:0] rp, input logic g, input logic v,
                     input logic [31:0] da, input logic rdy, input logic eq, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep);
    vec_t t;
    t.rst = r; t.redir = rd; t.rpc = rp; t.gnt = g; t.valid = v; t.daddr = da; t.rdy = rdy;
    t.ereq = eq; t.eaddr = ea; t.eifv = ev; t.eifpc = ep;
    tbl.push_back(t);
  endtask

  // Random-phase reference state: program-order PC and the single memory slot.
  logic [31:0] exp_pc, out_addr, rpc, data, prev_instr, prev_pc;
  logic [31:0] s_addr, s_instr, s_pc;
  logic        redir, gnt, rdy, valid, s_req, s_ifv, hold_prev;
  int          outstanding, delay, accepts;

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    ifb.redirect = 1'b0; ifb.redirectPC = 32'h0; ifb.imemGnt = 1'b0;
    ifb.imemValid = 1'b0; ifb.imemData = 32'h0; ifb.ifReady = 1'b1;

    // rst, redir, rpc, gnt, valid, data-addr, ready | req, addr, ifValid, ifPC
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 1'b0, 32'h4,   1'b0, 32'h0);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 1'b0, 32'h8,   1'b0, 32'h4);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8);
    row(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 1'b0, 32'h4,   1'b0, 32'h0);
    for (int i = 0; i < 5; i++)
      row(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h8,   1'b1, 32'h4);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 1'b0, 32'h8,   1'b0, 32'h4);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8);
    row(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b0, 32'h8);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 1'b0, 32'h8);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 1'b0, 32'h100, 1'b0, 32'h8);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h8);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h8);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h100);
    row(1'b1, 1'b1, 32'h203, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h104, 1'b0, 32'h100);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h100);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h200, 1'b0, 32'h100);
    row(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b1, 32'h200);
    row(1'b1, 1'b1, 32'h40,  1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b1, 32'h200);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h999, 1'b1, 1'b1, 32'h40,  1'b0, 32'h200);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  1'b1, 1'b0, 32'h40,  1'b0, 32'h200);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  1'b1, 32'h40);
    row(1'b1, 1'b1, 32'h80,  1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h44,  1'b0, 32'h40);
    row(1'b1, 1'b1, 32'hC0,  1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h80,  1'b0, 32'h40);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  1'b1, 1'b0, 32'hC0,  1'b0, 32'h40);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC0,  1'b0, 32'h40);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC0,  1'b1, 1'b0, 32'hC0,  1'b0, 32'h40);
    row(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC4,  1'b1, 32'hC0);

    @(negedge clk); #1;
    chk_a("reset_a", 1'b0, 32'h0, 1'b0, 32'h0);
    chk_b("reset_b", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_a_n = tbl[i].rst;
      drive_a(tbl[i].redir, tbl[i].rpc, tbl[i].gnt, tbl[i].valid, mem_of(tbl[i].daddr), tbl[i].rdy);
      #1;
      chk_a($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].eifv, tbl[i].eifpc);
    end

    // Async reset pulse while a fetch is outstanding; the late response must be ignored.
    @(negedge clk);
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    #2 rst_a_n = 1'b0;
    #1 chk_a("wait_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_a_n = 1'b1;
    drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_of(32'hC4), 1'b1);
    #1 chk_a("rst_rel", 1'b1, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1 chk_a("late_drop", 1'b1, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drive_a(1'b0, 32'h0, 1'b1, 1'b1, mem_of(32'h0), 1'b1);
    #1 chk_a("restart_w", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1 chk_a("restart_v", 1'b1, 32'h4, 1'b1, 32'h0);

    // PC wraparound from the top of the address space.
    @(negedge clk);
    rst_b_n = 1'b1; ifb.imemGnt = 1'b1;
    #1 chk_b("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    @(negedge clk);
    ifb.imemValid = 1'b1; ifb.imemData = mem_of(32'hFFFF_FFFC);
    #1 chk_b("wrap1", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    @(negedge clk);
    ifb.imemValid = 1'b0;
    #1 chk_b("wrap2", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    ifb.imemValid = 1'b1; ifb.imemData = mem_of(32'h0);
    #1 chk_b("wrap3", 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    @(negedge clk);
    ifb.imemValid = 1'b0;
    #1 chk_b("wrap4", 1'b1, 32'h4, 1'b1, 32'h0);

    // Random traffic against a program-order model of the fetch stream.
    @(negedge clk);
    rst_a_n = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    rst_a_n = 1'b1;
    exp_pc = 32'h0; outstanding = 0; delay = 0; accepts = 0; hold_prev = 1'b0;
    prev_instr = 32'h0; prev_pc = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : ($urandom & 32'h0000_0FFF);
      gnt   = ($urandom_range(0, 2) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      if (outstanding != 0 && delay == 0) begin
        valid = 1'b1; data = mem_of(out_addr);
      end else if (outstanding == 0 && $urandom_range(0, 7) == 0) begin
        valid = 1'b1; data = 32'hDEAD_BEEF;
      end else begin
        valid = 1'b0; data = $urandom;
      end
      drive_a(redir, rpc, gnt, valid, data, rdy);
      #1;
      s_req = ifa.imemReq; s_addr = ifa.imemAddr; s_ifv = ifa.ifValid;
      s_instr = ifa.ifInstr; s_pc = ifa.ifPC;

      if (s_req) begin
        check("one_outstanding", 32'(outstanding), 32'h0);
        check("fetch_addr", s_addr, s_ifv ? exp_pc + 32'd4 : exp_pc);
      end
      if (!s_ifv) check("nop_when_idle", s_instr, NOP);
      if (s_ifv && (!rdy || redir)) check("req_gated", 32'(s_req), 32'h0);
      if (hold_prev) begin
        check("hold_valid", 32'(s_ifv), 32'h1);
        check("hold_instr", s_instr, prev_instr);
        check("hold_pc", s_pc, prev_pc);
      end
      if (s_ifv && rdy && !redir) begin
        check("order_pc", s_pc, exp_pc);
        check("instr_data", s_instr, mem_of(s_pc));
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end

      if (outstanding != 0 && valid) outstanding = 0;
      else if (outstanding != 0) delay--;
      if (s_req && gnt) begin
        outstanding = 1;
        delay = $urandom_range(0, 2);
        out_addr = s_addr;
      end
      if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
      hold_prev  = s_ifv && !rdy && !redir;
      prev_instr = s_instr;
      prev_pc    = s_pc;
    end
    check("progress", 32'(accepts >= 50), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
